// File: rtl/stream_input_node.sv
// Grid-edge source node: host loads values into a FIFO, and a three-state write
// FSM offers them one at a time on a single fixed port using the req/ack handshake.
module stream_input_node #(
  parameter int DEPTH   = 16,
  parameter int OUT_DIR = 1,
  parameter int VAL_MAX = 999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               loadValid,
  input  logic signed [11:0] loadData,
  output logic               loadReady,
  output logic signed [11:0] upOut,
  output logic signed [11:0] downOut,
  output logic signed [11:0] leftOut,
  output logic signed [11:0] rightOut,
  output logic        [3:0]  requestWrite,
  output logic        [3:0]  ackRead,
  input  logic        [3:0]  dataReady,
  input  logic        [3:0]  ackWrite,
  output logic               fifoEmpty,
  output logic        [7:0]  sentCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]        DIR_MASK = 4'b0001 << OUT_DIR;
  localparam logic signed [11:0] VMAX    = 12'(VAL_MAX);
  localparam logic signed [11:0] VMIN    = -VMAX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic signed [11:0] saturate(input logic signed [11:0] v);
    if (v > VMAX) begin
      saturate = VMAX;
    end else if (v < VMIN) begin
      saturate = VMIN;
    end else begin
      saturate = v;
    end
  endfunction

  logic signed [11:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  state_t             state_r;
  state_t             state_s;
  logic signed [11:0] data_r;
  logic               req_r;
  logic [7:0]         sent_r;
  logic               push_s;
  logic               pop_s;
  logic               offer_s;
  logic               ack_s;
  logic               empty_s;
  logic               full_s;
  logic               unused_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == FULL_CNT);
  // Held low during reset so nothing is accepted while the node is cleared.
  assign loadReady = reset_n & ~full_s;
  assign push_s    = loadValid & loadReady;
  assign ack_s     = |(ackWrite & DIR_MASK);
  assign unused_s  = ^dataReady;

  assign upOut        = (OUT_DIR == 0) ? data_r : 12'sd0;
  assign downOut      = (OUT_DIR == 1) ? data_r : 12'sd0;
  assign leftOut      = (OUT_DIR == 2) ? data_r : 12'sd0;
  assign rightOut     = (OUT_DIR == 3) ? data_r : 12'sd0;
  assign requestWrite = req_r ? DIR_MASK : 4'b0000;
  assign ackRead      = 4'b0000;
  assign fifoEmpty    = empty_s;
  assign sentCount    = sent_r;

  // FIFO storage; the saturated value lands at the tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= saturate(loadData);
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; RELEASE waits for the ack to drop so a held ack pops only once.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    offer_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          offer_s = 1'b1;
          state_s = OFFER;
        end else begin
          state_s = IDLE;
        end
      end
      OFFER: begin
        if (ack_s) begin
          pop_s   = 1'b1;
          state_s = RELEASE;
        end else begin
          state_s = OFFER;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered port data, request and delivery counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r <= 12'sd0;
      req_r  <= 1'b0;
      sent_r <= 8'd0;
    end else begin
      if (offer_s) begin
        data_r <= mem_r[rd_ptr_r];
        req_r  <= 1'b1;
      end else if (pop_s) begin
        req_r  <= 1'b0;
        sent_r <= sent_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_stream_input_node.sv
// Scoreboard bench for stream_input_node (OUT_DIR = down): loads push the expected
// saturated value, each observed offer pops and compares.
module tb_stream_input_node;

  logic               clk;
  logic               reset_n;
  logic               loadValid;
  logic signed [11:0] loadData;
  logic               loadReady;
  logic signed [11:0] upOut, downOut, leftOut, rightOut;
  logic [3:0]         requestWrite;
  logic [3:0]         ackRead;
  logic [3:0]         dataReady;
  logic [3:0]         ackWrite;
  logic               fifoEmpty;
  logic [7:0]         sentCount;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_sent = 0;
  logic signed [11:0] sb[$];

  stream_input_node #(.DEPTH(16), .OUT_DIR(1), .VAL_MAX(999)) dut (
    .clk(clk), .reset_n(reset_n), .loadValid(loadValid), .loadData(loadData),
    .loadReady(loadReady), .upOut(upOut), .downOut(downOut), .leftOut(leftOut),
    .rightOut(rightOut), .requestWrite(requestWrite), .ackRead(ackRead),
    .dataReady(dataReady), .ackWrite(ackWrite), .fifoEmpty(fifoEmpty),
    .sentCount(sentCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background check: only the down request bit may ever be raised, ackRead stays 0.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && requestWrite !== 4'b0000 && requestWrite !== 4'b0010) begin
      n_fail++;
      $display("FAIL req_dir: requestWrite=%b expected 0000 or 0010", requestWrite);
    end
    if (ackRead !== 4'b0000) begin
      n_fail++;
      $display("FAIL ack_read: ackRead=%b expected 0000", ackRead);
    end
  end

  function automatic logic signed [11:0] sat_model(input int v);
    int r;
    r = (v > 999) ? 999 : ((v < -999) ? -999 : v);
    return 12'(r);
  endfunction

  task automatic load(input int v);
    logic exp_rdy;
    exp_rdy = (sb.size() < 16);
    n_tests++;
    if (loadReady !== exp_rdy) begin
      n_fail++;
      $display("FAIL load_ready: got %b expected %b (value %0d)", loadReady, exp_rdy, v);
    end
    loadValid = 1'b1;
    loadData  = 12'(v);
    @(negedge clk);
    loadValid = 1'b0;
    if (exp_rdy) sb.push_back(sat_model(v));
  endtask

  task automatic wait_req(output bit ok);
    int k;
    k = 0;
    while (requestWrite[1] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    ok = (requestWrite[1] === 1'b1);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: requestWrite=%b expected 0010 within 40 cycles", requestWrite);
    end
  endtask

  task automatic check_offer(input string name);
    logic signed [11:0] exp;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_extra: got offer %0d, expected no offer", name, downOut);
    end else begin
      exp = sb.pop_front();
      if (downOut !== exp) begin
        n_fail++;
        $display("FAIL %s_data: downOut=%0d expected %0d", name, downOut, exp);
      end
    end
    n_tests++;
    if (upOut !== 12'sd0 || leftOut !== 12'sd0 || rightOut !== 12'sd0) begin
      n_fail++;
      $display("FAIL %s_other_ports: up=%0d left=%0d right=%0d expected 0", name, upOut, leftOut, rightOut);
    end
  endtask

  task automatic deliver(input int delay, input string name);
    bit ok;
    wait_req(ok);
    if (ok) begin
      check_offer(name);
      repeat (delay) @(negedge clk);
      ackWrite = 4'b0010;
      @(negedge clk);
      exp_sent++;
      n_tests++;
      if (requestWrite !== 4'b0000 || sentCount !== 8'(exp_sent)) begin
        n_fail++;
        $display("FAIL %s_pop: req=%b sent=%0d expected req=0000 sent=%0d", name, requestWrite, sentCount, exp_sent);
      end
      ackWrite = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit ok;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (requestWrite !== 4'b0000 || fifoEmpty !== 1'b1 || sentCount !== 8'd0 || loadReady !== 1'b0 || downOut !== 12'sd0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b empty=%b sent=%0d ready=%b down=%0d expected 0000 1 0 0 0",
               requestWrite, fifoEmpty, sentCount, loadReady, downOut);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (loadReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: loadReady=%b expected 1", loadReady);
    end
    @(negedge clk);
    load(11);
    load(22);
    deliver(1, "pre_reset");
    wait_req(ok);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (requestWrite !== 4'b0000 || downOut !== 12'sd0 || sentCount !== 8'd0 || fifoEmpty !== 1'b1 || loadReady !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b down=%0d sent=%0d empty=%b ready=%b expected 0000 0 0 1 0",
               requestWrite, downOut, sentCount, fifoEmpty, loadReady);
    end
    sb.delete();
    exp_sent = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (loadReady !== 1'b1 || requestWrite !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset: ready=%b req=%b expected 1 0000", loadReady, requestWrite);
    end
    @(negedge clk);
  endtask

  task automatic test_order;
    load(5);
    load(-7);
    load(300);
    for (int i = 0; i < 3; i++) deliver(2, "order");
    n_tests++;
    if (sentCount !== 8'd3 || fifoEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL order_end: sent=%0d empty=%b expected 3 1", sentCount, fifoEmpty);
    end
  endtask

  task automatic test_saturation;
    load(1500);
    load(-2048);
    load(999);
    load(-999);
    for (int i = 0; i < 4; i++) deliver(0, "sat");
  endtask

  task automatic test_full;
    for (int v = 1; v <= 17; v++) load(v);
    n_tests++;
    if (loadReady !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: loadReady=%b expected 0", loadReady);
    end
    for (int i = 0; i < 16; i++) deliver(0, "full");
    repeat (5) @(negedge clk);
    n_tests++;
    if (requestWrite !== 4'b0000 || fifoEmpty !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: req=%b empty=%b left=%0d expected 0000 1 0", requestWrite, fifoEmpty, sb.size());
    end
  endtask

  task automatic test_held_ack;
    bit ok;
    load(10);
    load(20);
    load(30);
    wait_req(ok);
    check_offer("held");
    ackWrite = 4'b0010;
    repeat (10) @(negedge clk);
    exp_sent++;
    n_tests++;
    if (sentCount !== 8'(exp_sent) || requestWrite !== 4'b0000) begin
      n_fail++;
      $display("FAIL held_one_pop: sent=%0d req=%b expected %0d 0000", sentCount, requestWrite, exp_sent);
    end
    ackWrite = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (requestWrite !== 4'b0000) begin
      n_fail++;
      $display("FAIL held_edge1: req=%b expected 0000", requestWrite);
    end
    @(negedge clk);
    n_tests++;
    if (requestWrite !== 4'b0010) begin
      n_fail++;
      $display("FAIL held_edge2: req=%b expected 0010", requestWrite);
    end
    deliver(0, "held_rest");
    deliver(0, "held_rest");
  endtask

  task automatic test_ignored;
    bit ok;
    logic signed [11:0] head;
    load(42);
    load(-43);
    wait_req(ok);
    head = sb[0];
    ackWrite  = 4'b1001;
    dataReady = 4'b1111;
    repeat (3) @(negedge clk);
    n_tests++;
    if (requestWrite !== 4'b0010 || sentCount !== 8'(exp_sent) || downOut !== head) begin
      n_fail++;
      $display("FAIL ignored: req=%b sent=%0d down=%0d expected 0010 %0d %0d",
               requestWrite, sentCount, downOut, exp_sent, head);
    end
    ackWrite  = 4'b0000;
    dataReady = 4'b0000;
    deliver(1, "ignored");
    deliver(1, "ignored");
  endtask

  initial begin
    reset_n   = 1'b0;
    loadValid = 1'b0;
    loadData  = 12'sd0;
    dataReady = 4'b0000;
    ackWrite  = 4'b0000;
    @(negedge clk);
    test_reset();
    test_order();
    test_saturation();
    test_full();
    test_held_ack();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
